// File: rtl/dpbr_8_32_csum_pkg.sv
// Shared constants for the packet response buffer: address widths, byte-lane mapping
// and checksum width.
package dpbr_8_32_csum_pkg;

  localparam int unsigned AW_A_DFLT = 10;
  localparam int unsigned AW_B_DFLT = 12;
  localparam int unsigned CSUM_W    = 16;
  localparam int unsigned LANE_W    = 8;

  // Byte lane n of a 32-bit word sits at bits [8n+7:8n] (little-endian lanes).
  function automatic int unsigned lane_lsb(input logic [1:0] lane);
    return int'(lane) * LANE_W;
  endfunction

endpackage

// File: rtl/dpbr_8_32_csum_csum.sv
// Byte-serial RFC 1071 ones'-complement accumulator with end-around carry fold.
module ip_checksum_8bit
  import dpbr_8_32_csum_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              dv_even,
  input  logic              dv_odd,
  input  logic [7:0]        data,
  output logic [CSUM_W-1:0] checksum
);

  logic [CSUM_W-1:0] acc;
  logic [CSUM_W-1:0] addend;
  logic [CSUM_W:0]   sum;
  logic [CSUM_W-1:0] folded;

  always_comb begin
    addend = {(dv_even ? data : 8'h00), (dv_odd ? data : 8'h00)};
    sum    = {1'b0, acc} + {1'b0, addend};
    // sum[15:0] is at most 16'hFFFE when the carry is set, so the fold cannot overflow.
    folded = sum[CSUM_W-1:0] + {{(CSUM_W-1){1'b0}}, sum[CSUM_W]};
  end

  always_ff @(posedge clk) begin
    if (reset || clr)
      acc <= '0;
    else if (dv_even || dv_odd)
      acc <= folded;
  end

  assign checksum = ~acc;

endmodule

// File: rtl/dpbr_8_32_csum.sv
// Two-page response buffer (32-bit write / 8-bit read-write, read-first) plus the
// transmit checksum accumulator.
module dpbr_8_32_csum
  import dpbr_8_32_csum_pkg::*;
#(
  parameter int unsigned AW_A = AW_A_DFLT,
  parameter int unsigned AW_B = AW_B_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wea,
  input  logic [AW_A-1:0]   addra,
  input  logic [31:0]       dina,
  input  logic              web,
  input  logic [AW_B-1:0]   addrb,
  input  logic [7:0]        dinb,
  output logic [7:0]        doutb,
  input  logic              csum_clr,
  input  logic              dv_even,
  input  logic              dv_odd,
  input  logic [7:0]        data,
  output logic [CSUM_W-1:0] checksum
);

  logic [31:0] mem [2**AW_A];
  logic [7:0]  rd_q = '0;

  logic [AW_A-1:0] word_b;
  logic [1:0]      lane_b;

  assign word_b = addrb[AW_B-1:2];
  assign lane_b = addrb[1:0];

  // Single process keeps the array single-driven; port A is assigned last so it
  // wins a same-byte collision, and the read uses pre-edge contents (read-first).
  always_ff @(posedge clk) begin
    rd_q <= mem[word_b][lane_lsb(lane_b) +: LANE_W];
    if (web)
      mem[word_b][lane_lsb(lane_b) +: LANE_W] <= dinb;
    if (wea)
      mem[addra] <= dina;
  end

  assign doutb = rd_q;

  ip_checksum_8bit u_csum (
    .clk      (clk),
    .reset    (reset),
    .clr      (csum_clr),
    .dv_even  (dv_even),
    .dv_odd   (dv_odd),
    .data     (data),
    .checksum (checksum)
  );

endmodule

// File: tb/tb_dpbr_8_32_csum.sv
// Directed bench for dpbr_8_32_csum: buffer mapping, read-first/collision and checksum.
module tb_dpbr_8_32_csum;

  logic        clk = 1'b0;
  logic        reset;
  logic        wea;
  logic [9:0]  addra;
  logic [31:0] dina;
  logic        web;
  logic [11:0] addrb;
  logic [7:0]  dinb;
  logic [7:0]  doutb;
  logic        csum_clr;
  logic        dv_even;
  logic        dv_odd;
  logic [7:0]  data;
  logic [15:0] checksum;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0] ip_hdr [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00,
                              8'h40, 8'h11, 8'h00, 8'h00, 8'hc0, 8'ha8, 8'h00, 8'h01,
                              8'hc0, 8'ha8, 8'h00, 8'hc7};
  logic [7:0] rd_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  dpbr_8_32_csum #(.AW_A(10), .AW_B(12)) dut (
    .clk      (clk),
    .reset    (reset),
    .wea      (wea),
    .addra    (addra),
    .dina     (dina),
    .web      (web),
    .addrb    (addrb),
    .dinb     (dinb),
    .doutb    (doutb),
    .csum_clr (csum_clr),
    .dv_even  (dv_even),
    .dv_odd   (dv_odd),
    .data     (data),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] exp);
    checks++;
    assert (doutb === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, doutb, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] exp);
    checks++;
    assert (checksum === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, checksum, exp);
    end
  endtask

  initial begin
    reset = 1'b1; wea = 1'b0; addra = '0; dina = '0; web = 1'b0; addrb = '0;
    dinb = '0; csum_clr = 1'b0; dv_even = 1'b0; dv_odd = 1'b0; data = '0;
    #1;
    chk8("doutb_config", 8'h00);
    tick();
    reset = 1'b0;
    chk16("csum_reset", 16'hFFFF);

    // word write, byte readback
    wea = 1'b1; addra = 10'd5; dina = 32'h44332211;
    tick();
    wea = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addrb = 12'(20 + i);
      tick();
      chk8($sformatf("word5_byte%0d", 20 + i), rd_exp[i]);
    end

    // page isolation
    wea = 1'b1; addra = 10'd0; dina = 32'hAAAAAAAA;
    tick();
    addra = 10'd512; dina = 32'h55555555;
    tick();
    wea = 1'b0;
    addrb = 12'd0;
    tick();
    chk8("page0_byte0", 8'hAA);
    addrb = 12'd2048;
    tick();
    chk8("page1_byte2048", 8'h55);
    tick();
    chk8("doutb_hold", 8'h55);

    // read-first on port B write
    addrb = 12'd20; web = 1'b1; dinb = 8'h77;
    tick();
    web = 1'b0;
    chk8("readfirst_old", 8'h11);
    tick();
    chk8("readfirst_new", 8'h77);

    // both ports write byte 20: port A wins; read returns old data
    wea = 1'b1; addra = 10'd5; dina = 32'hDDCCBBEE;
    web = 1'b1; dinb = 8'h99;
    tick();
    wea = 1'b0; web = 1'b0;
    chk8("collision_old", 8'h77);
    tick();
    chk8("collision_porta_wins", 8'hEE);
    addrb = 12'd21;
    tick();
    chk8("collision_other_lane", 8'hBB);

    // IP header checksum
    for (int i = 0; i < 20; i++) begin
      dv_even = (i % 2 == 0);
      dv_odd  = (i % 2 == 1);
      data    = ip_hdr[i];
      tick();
      if (i == 0) chk16("csum_latency", 16'hBAFF);
    end
    dv_even = 1'b0; dv_odd = 1'b0; data = '0;
    chk16("ip_header", 16'hB861);

    // carry fold
    csum_clr = 1'b1;
    tick();
    csum_clr = 1'b0;
    chk16("csum_clr", 16'hFFFF);
    for (int i = 0; i < 6; i++) begin
      dv_even = (i % 2 == 0);
      dv_odd  = (i % 2 == 1);
      data    = (i < 4) ? 8'hFF : ((i == 4) ? 8'h00 : 8'h01);
      tick();
    end
    dv_even = 1'b0; dv_odd = 1'b0;
    chk16("carry_fold", 16'hFFFE);

    // both strobes: addend {12,12}, acc 0001 + 1212 = 1213
    dv_even = 1'b1; dv_odd = 1'b1; data = 8'h12;
    tick();
    dv_even = 1'b0; dv_odd = 1'b0;
    chk16("both_strobes", 16'hEDEC);
    tick();
    chk16("no_strobe_hold", 16'hEDEC);

    // clear beats same-cycle strobe
    csum_clr = 1'b1; dv_even = 1'b1; data = 8'h55;
    tick();
    csum_clr = 1'b0; dv_even = 1'b0;
    chk16("clr_priority", 16'hFFFF);

    // odd trailing byte is zero-padded
    dv_even = 1'b1; data = 8'h12;
    tick();
    dv_even = 1'b0;
    chk16("odd_byte", 16'hEDFF);

    // reset mid-stream clears accumulator, buffer reads continue
    reset = 1'b1; dv_odd = 1'b1; data = 8'h34; addrb = 12'd2048;
    tick();
    reset = 1'b0; dv_odd = 1'b0;
    chk16("reset_midstream", 16'hFFFF);
    chk8("reset_buffer_intact", 8'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
